// File: rtl/qtree_pkg.sv
// Shared types and helpers for the n-ary search-tree lookup stage.
// The typedefs describe a node at the default geometry (16-bit keys,
// 8-bit addresses, fanout 4); stages with other widths build their own
// local types but share the FANOUT_BITS helper.
package qtree_pkg;

    localparam int KEY_W_DEF  = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int FANOUT_DEF = 4;

    typedef logic [KEY_W_DEF-1:0] node_key_t;

    // Sorted key array of one node, key 0 in the LSBs.
    typedef node_key_t [FANOUT_DEF-2:0] node_keys_t;

    // One lookup travelling down the tree.
    typedef struct packed {
        logic [KEY_W_DEF-1:0]  key;
        logic [ADDR_W_DEF-1:0] addr;
    } lookup_t;

    // Number of child-select bits a node of the given fanout contributes.
    function automatic int fanout_bits(input int fanout);
        return $clog2(fanout);
    endfunction

endpackage

// File: rtl/qstage_skid.sv
// Two-entry output skid buffer with registered valid and data outputs.
// Accepts a push while full provided the head is popped on the same edge.
module qstage_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [1:0]            count_o
);

    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  push;
    logic                  pop;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = count_q;
    assign pop         = out_valid_o && out_ready_i;
    assign in_ready_o  = (count_q != 2'd2) || pop;
    assign push        = in_valid_i && in_ready_o;

    // Occupancy bookkeeping.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Only the occupancy is reset; stale entry data is never observable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage: head is always the oldest entry.
    always_ff @(posedge clk_i) begin
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_q <= in_data_i;
                end else begin
                    tail_q <= in_data_i;
                end
            end
            2'b01: head_q <= tail_q;
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_q <= in_data_i;
                end else begin
                    head_q <= tail_q;
                    tail_q <= in_data_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qstage_nary.sv
// One level of an n-ary search tree: reads the node addressed by the
// lookup, finds the child slot for the key and emits the child address.
// Optional feature macro: QSTAGE_NARY_MATCH_EN adds out_match_o (exact key hit).
module qstage_nary
    import qtree_pkg::*;
#(
    parameter  int KEY_WIDTH      = 16,
    parameter  int ADDR_WIDTH     = 8,
    parameter  int RAM_ADDR_WIDTH = 4,
    parameter  int FANOUT         = 4,
    parameter  int BYPASS_WIDTH   = 1,
    localparam int RAM_DATA_WIDTH = KEY_WIDTH * (FANOUT - 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [RAM_ADDR_WIDTH-1:0] mm_ram_addr_i,
    input  logic [RAM_DATA_WIDTH-1:0] mm_ram_data_i,
    input  logic                      mm_ram_write_i,
    input  logic [KEY_WIDTH-1:0]      in_key_i,
    input  logic [ADDR_WIDTH-1:0]     in_addr_i,
    input  logic [BYPASS_WIDTH-1:0]   in_bypass_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [KEY_WIDTH-1:0]      out_key_o,
    output logic [ADDR_WIDTH-1:0]     out_addr_o,
    output logic [BYPASS_WIDTH-1:0]   out_bypass_o,
    output logic                      out_valid_o,
`ifdef QSTAGE_NARY_MATCH_EN
    output logic                      out_match_o,
`endif
    input  logic                      out_ready_i
);

    localparam int FB = fanout_bits(FANOUT);
`ifdef QSTAGE_NARY_MATCH_EN
    localparam int PAY_W = KEY_WIDTH + ADDR_WIDTH + BYPASS_WIDTH + 1;
`else
    localparam int PAY_W = KEY_WIDTH + ADDR_WIDTH + BYPASS_WIDTH;
`endif

    if (FANOUT < 2 || FANOUT > 16 || (FANOUT & (FANOUT - 1)) != 0) begin : g_bad_fanout
        $error("qstage_nary: FANOUT must be a power of two in 2..16");
    end
    if (RAM_ADDR_WIDTH > ADDR_WIDTH) begin : g_bad_ram_addr
        $error("qstage_nary: RAM_ADDR_WIDTH must not exceed ADDR_WIDTH");
    end

    logic [RAM_DATA_WIDTH-1:0] ram_q [2**RAM_ADDR_WIDTH];

    logic [RAM_DATA_WIDTH-1:0] rd_data_p1_q;
    logic [KEY_WIDTH-1:0]      key_p1_q;
    logic [ADDR_WIDTH-1:0]     addr_p1_q;
    logic [BYPASS_WIDTH-1:0]   bypass_p1_q;
    logic                      vld_p1_q, vld_p1_d;

    logic                      accept;
    logic [2:0]                occ;
    logic                      skid_rdy;
    logic                      skid_push;
    logic                      skid_vld;
    logic                      skid_pop;
    logic [1:0]                skid_cnt;
    logic [FB-1:0]             postfix;
    logic [ADDR_WIDTH-1:0]     child_addr;
    logic [PAY_W-1:0]          pay_in;
    logic [PAY_W-1:0]          pay_out;
`ifdef QSTAGE_NARY_MATCH_EN
    logic                      match_p1;
`endif

    // Entries that will still be held after this edge: the skid contents
    // minus any pop happening now, plus the lookup in the compare stage.
    // Counting the pop keeps full throughput while out_ready_i is high.
    assign skid_pop   = skid_vld && out_ready_i;
    assign occ        = {1'b0, skid_cnt} - {2'b00, skid_pop} + {2'b00, vld_p1_q};
    assign in_ready_o = !rst_i && (occ < 3'd2);
    assign accept     = in_valid_i && in_ready_o;
    assign skid_push  = vld_p1_q && skid_rdy;
    assign vld_p1_d   = accept || (vld_p1_q && !skid_rdy);

    // Node RAM write port; never reset.
    always_ff @(posedge clk_i) begin
        if (mm_ram_write_i) begin
            ram_q[mm_ram_addr_i] <= mm_ram_data_i;
        end
    end

    // Stage p0 -> p1: registered RAM read (old data on a same-edge write) plus payload.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rd_data_p1_q <= ram_q[in_addr_i[RAM_ADDR_WIDTH-1:0]];
            key_p1_q     <= in_key_i;
            addr_p1_q    <= in_addr_i;
            bypass_p1_q  <= in_bypass_i;
        end
    end

    // Stage p1 valid; cleared by reset so in-flight lookups are discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    // Stage p1 compare: smallest slot whose key is >= the lookup key
    // (scanned from the top so the lowest hit wins), else the last child.
    always_comb begin
        postfix = FB'(FANOUT - 1);
`ifdef QSTAGE_NARY_MATCH_EN
        match_p1 = 1'b0;
`endif
        for (int i = FANOUT - 2; i >= 0; i--) begin
            if (key_p1_q <= rd_data_p1_q[i*KEY_WIDTH +: KEY_WIDTH]) begin
                postfix = FB'(i);
`ifdef QSTAGE_NARY_MATCH_EN
                match_p1 = (key_p1_q == rd_data_p1_q[i*KEY_WIDTH +: KEY_WIDTH]);
`endif
            end
        end
    end

    assign child_addr = ADDR_WIDTH'({addr_p1_q, postfix});

`ifdef QSTAGE_NARY_MATCH_EN
    assign pay_in = {match_p1, bypass_p1_q, child_addr, key_p1_q};
`else
    assign pay_in = {bypass_p1_q, child_addr, key_p1_q};
`endif

    qstage_skid #(
        .DATA_WIDTH (PAY_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (skid_push),
        .in_data_i   (pay_in),
        .in_ready_o  (skid_rdy),
        .out_valid_o (skid_vld),
        .out_data_o  (pay_out),
        .out_ready_i (out_ready_i),
        .count_o     (skid_cnt)
    );

    assign out_valid_o  = skid_vld;
    assign out_key_o    = pay_out[KEY_WIDTH-1:0];
    assign out_addr_o   = pay_out[KEY_WIDTH +: ADDR_WIDTH];
    assign out_bypass_o = pay_out[KEY_WIDTH+ADDR_WIDTH +: BYPASS_WIDTH];
`ifdef QSTAGE_NARY_MATCH_EN
    assign out_match_o  = skid_vld && pay_out[PAY_W-1];
`endif

endmodule

// File: tb/tb_qstage_nary.sv
// Directed bench for qstage_nary at FANOUT=4, 16-bit keys, 8-bit addresses.
module tb_qstage_nary;

    localparam int KW  = 16;
    localparam int AW  = 8;
    localparam int RAW = 4;
    localparam int FO  = 4;
    localparam int BW  = 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [RAW-1:0] mm_ram_addr_i = '0;
    logic [47:0]   mm_ram_data_i = '0;
    logic          mm_ram_write_i = 1'b0;
    logic [KW-1:0] in_key_i = '0;
    logic [AW-1:0] in_addr_i = '0;
    logic [BW-1:0] in_bypass_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [KW-1:0] out_key_o;
    logic [AW-1:0] out_addr_o;
    logic [BW-1:0] out_bypass_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
`ifdef QSTAGE_NARY_MATCH_EN
    logic          out_match_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [47:0] shadow [16];

    typedef struct {
        logic [15:0] key;
        logic [7:0]  addr;
        logic        bp;
        logic        m;
    } exp_t;

    always #5 clk = ~clk;

    qstage_nary #(
        .KEY_WIDTH      (KW),
        .ADDR_WIDTH     (AW),
        .RAM_ADDR_WIDTH (RAW),
        .FANOUT         (FO),
        .BYPASS_WIDTH   (BW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mm_ram_addr_i  (mm_ram_addr_i),
        .mm_ram_data_i  (mm_ram_data_i),
        .mm_ram_write_i (mm_ram_write_i),
        .in_key_i       (in_key_i),
        .in_addr_i      (in_addr_i),
        .in_bypass_i    (in_bypass_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .out_key_o      (out_key_o),
        .out_addr_o     (out_addr_o),
        .out_bypass_o   (out_bypass_o),
        .out_valid_o    (out_valid_o),
`ifdef QSTAGE_NARY_MATCH_EN
        .out_match_o    (out_match_o),
`endif
        .out_ready_i    (out_ready_i)
    );

    function automatic int model_postfix(input logic [15:0] key, input logic [47:0] node);
        for (int i = 0; i < 3; i++) begin
            if (key <= node[i*16 +: 16]) return i;
        end
        return 3;
    endfunction

    function automatic exp_t make_exp(input logic [15:0] key, input logic [7:0] addr, input logic bp);
        exp_t e;
        int pf;
        logic [47:0] node;
        node   = shadow[addr[3:0]];
        pf     = model_postfix(key, node);
        e.key  = key;
        e.addr = 8'((int'(addr) << 2) | pf);
        e.bp   = bp;
        e.m    = 1'b0;
        if (pf < 3) e.m = (key == node[pf*16 +: 16]);
        return e;
    endfunction

    task automatic ram_write(input logic [3:0] a, input logic [47:0] d);
        mm_ram_addr_i  = a;
        mm_ram_data_i  = d;
        mm_ram_write_i = 1'b1;
        @(posedge clk); #1;
        mm_ram_write_i = 1'b0;
        shadow[a] = d;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid_o);
        if (out_valid_o !== 1'b0) errors++;
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
`ifdef QSTAGE_NARY_MATCH_EN
        checks++;
        if (out_match_o !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", out_match_o); end
`endif
        rst_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready_o); end
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", out_valid_o); end
    endtask

    task automatic test_lookup();
        int          keys [3];
        logic [7:0]  ea   [3];
        logic        em   [3];
        keys = '{15, 20, 31};
        ea   = '{8'h0D, 8'h0D, 8'h0F};
        em   = '{1'b0, 1'b1, 1'b0};
        out_ready_i = 1'b1;
        ram_write(4'd3, {16'd30, 16'd20, 16'd10});
        for (int j = 0; j < 5; j++) begin
            in_valid_i  = (j < 3);
            in_key_i    = (j < 3) ? 16'(keys[j]) : 16'd0;
            in_addr_i   = 8'd3;
            in_bypass_i = 1'b0;
            #1;
            checks++;
            if (out_valid_o !== (j >= 2)) begin
                errors++;
                $display("FAIL lookup_valid[%0d]: got %b want %b", j, out_valid_o, (j >= 2));
            end
            if (j >= 2) begin
                checks++;
                if (out_addr_o !== ea[j-2] || out_key_o !== 16'(keys[j-2])) begin
                    errors++;
                    $display("FAIL lookup_addr[%0d]: got addr %h key %0d want addr %h key %0d",
                             j - 2, out_addr_o, out_key_o, ea[j-2], keys[j-2]);
                end
`ifdef QSTAGE_NARY_MATCH_EN
                checks++;
                if (out_match_o !== em[j-2]) begin
                    errors++;
                    $display("FAIL lookup_match[%0d]: got %b want %b", j - 2, out_match_o, em[j-2]);
                end
`endif
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t ex [16];
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) ex[i] = make_exp(16'(i * 3), 8'(i * 16 + 3), 1'(i));
        for (int j = 0; j < 18; j++) begin
            in_valid_i  = (j < 16);
            in_key_i    = 16'(j * 3);
            in_addr_i   = 8'(j * 16 + 3);
            in_bypass_i = 1'(j);
            #1;
            if (j < 16) begin
                checks++;
                if (in_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1", j, in_ready_o);
                end
            end
            checks++;
            if (out_valid_o !== (j >= 2)) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", j, out_valid_o, (j >= 2));
            end
            if (j >= 2) begin
                checks++;
                if (out_key_o !== ex[j-2].key || out_addr_o !== ex[j-2].addr || out_bypass_o !== ex[j-2].bp) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got key %0d addr %h bp %b want key %0d addr %h bp %b",
                             j - 2, out_key_o, out_addr_o, out_bypass_o, ex[j-2].key, ex[j-2].addr, ex[j-2].bp);
                end
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] ea [2];
        ea = '{8'h0F, 8'h0D};
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            mm_ram_write_i = (j == 0);
            mm_ram_addr_i  = 4'd3;
            mm_ram_data_i  = {16'd300, 16'd200, 16'd100};
            in_valid_i     = (j < 2);
            in_key_i       = 16'd150;
            in_addr_i      = 8'd3;
            in_bypass_i    = 1'b1;
            #1;
            if (j >= 2) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_addr_o !== ea[j-2]) begin
                    errors++;
                    $display("FAIL collision[%0d]: got valid %b addr %h want valid 1 addr %h",
                             j - 2, out_valid_o, out_addr_o, ea[j-2]);
                end
`ifdef QSTAGE_NARY_MATCH_EN
                checks++;
                if (out_match_o !== 1'b0) begin
                    errors++;
                    $display("FAIL collision_match[%0d]: got %b want 0", j - 2, out_match_o);
                end
`endif
            end
            @(posedge clk); #1;
        end
        mm_ram_write_i = 1'b0;
        in_valid_i     = 1'b0;
        shadow[3]      = {16'd300, 16'd200, 16'd100};
    endtask

    task automatic test_random_stall();
        exp_t        q [$];
        exp_t        e;
        int          sent;
        int          n;
        int          outst;
        bit          stalled;
        bit          pop;
        logic [15:0] pk;
        logic [7:0]  pa;
        logic        pb;
        logic [15:0] k0, k1, k2;
        for (int a = 0; a < 16; a++) begin
            k0 = 16'($urandom_range(0, 900));
            k1 = k0 + 16'($urandom_range(0, 900));
            k2 = k1 + 16'($urandom_range(0, 900));
            ram_write(4'(a), {k2, k1, k0});
        end
        sent    = 0;
        n       = 0;
        stalled = 1'b0;
        pk = '0; pa = '0; pb = 1'b0;
        while ((sent < 1000 || q.size() != 0) && n < 20000) begin
            in_valid_i  = (sent < 1000);
            in_key_i    = 16'($urandom_range(0, 2800));
            in_addr_i   = 8'($urandom);
            in_bypass_i = 1'($urandom);
            out_ready_i = ($urandom_range(0, 99) < 30);
            #1;
            pop = out_valid_o && out_ready_i;
            if (stalled) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_key_o !== pk || out_addr_o !== pa || out_bypass_o !== pb) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %b key %0d addr %h want valid 1 key %0d addr %h",
                             out_valid_o, out_key_o, out_addr_o, pk, pa);
                end
            end
            outst = q.size() - (pop ? 1 : 0);
            checks++;
            if (in_ready_o !== (outst < 2)) begin
                errors++;
                $display("FAIL rand_ready: got %b want %b (held %0d)", in_ready_o, (outst < 2), q.size());
            end
            if (pop) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got output key %0d want none", out_key_o);
                end else begin
                    e = q.pop_front();
                    if (out_key_o !== e.key || out_addr_o !== e.addr || out_bypass_o !== e.bp) begin
                        errors++;
                        $display("FAIL rand_data: got key %0d addr %h bp %b want key %0d addr %h bp %b",
                                 out_key_o, out_addr_o, out_bypass_o, e.key, e.addr, e.bp);
                    end
`ifdef QSTAGE_NARY_MATCH_EN
                    checks++;
                    if (out_match_o !== e.m) begin
                        errors++;
                        $display("FAIL rand_match: got %b want %b", out_match_o, e.m);
                    end
`endif
                end
            end
            if (in_valid_i && in_ready_o) begin
                q.push_back(make_exp(in_key_i, in_addr_i, in_bypass_i));
                sent++;
            end
            stalled = out_valid_o && !out_ready_i;
            pk = out_key_o;
            pa = out_addr_o;
            pb = out_bypass_o;
            @(posedge clk); #1;
            n++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL rand_timeout: got %0d sent, %0d pending want 1000 sent, 0 pending", sent, q.size());
        end
    endtask

    task automatic test_reset_stall();
        out_ready_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_valid_i  = 1'b1;
            in_key_i    = 16'(j);
            in_addr_i   = 8'd5;
            in_bypass_i = 1'b0;
            #1;
            checks++;
            if (in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rs_fill_ready[%0d]: got %b want 1", j, in_ready_o);
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rs_full: got valid %b ready %b want valid 1 ready 0", out_valid_o, in_ready_o);
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rs_valid_cleared: got %b want 0", out_valid_o);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rs_ready: got %b want 1", in_ready_o);
        end
        out_ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rs_stale[%0d]: got valid %b key %0d want valid 0", j, out_valid_o, out_key_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_back_to_back();
        test_collision();
        test_random_stall();
        test_reset_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qstage_nary.md
QSTAGE_NARY -- requirements
Module: qstage_nary

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 16: lookup key and node key width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: node address width, in and out.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default 4: node RAM depth is 2**RAM_ADDR_WIDTH.
REQ-004 SHALL have parameter FANOUT, default 4: power of two, 2..16; node holds FANOUT-1 sorted keys.
REQ-005 SHALL have parameter BYPASS_WIDTH, default 1: opaque sideband carried alongside each lookup.
REQ-006 SHALL have derived parameter RAM_DATA_WIDTH = KEY_WIDTH*(FANOUT-1), with key 0 in the LSBs.
REQ-007 SHALL have ports: clk_i in 1, the single clock; rst_i in 1, synchronous active-high reset.
REQ-008 SHALL have ports: mm_ram_addr_i in RAM_ADDR_WIDTH; mm_ram_data_i in RAM_DATA_WIDTH; mm_ram_write_i in 1.
REQ-009 SHALL have input-side ports: in_key_i in KEY_WIDTH; in_addr_i in ADDR_WIDTH; in_bypass_i in BYPASS_WIDTH; in_valid_i in 1; in_ready_o out 1.
REQ-010 SHALL have output-side ports: out_key_o out KEY_WIDTH; out_addr_o out ADDR_WIDTH; out_bypass_o out BYPASS_WIDTH; out_valid_o out 1; out_ready_i in 1.

Function
REQ-011 Transfer SHALL occur on any edge where valid and ready are both high; in_ready_o SHALL NOT depend combinationally on in_valid_i.
REQ-012 The RAM read address SHALL be in_addr_i[RAM_ADDR_WIDTH-1:0]; read data SHALL be registered (1 cycle).
REQ-013 postfix SHALL be the smallest i with in_key <= key[i], or FANOUT-1 if there is none; all compares are unsigned.
REQ-014 out_addr_o SHALL be ((in_addr << log2(FANOUT)) | postfix), truncated to ADDR_WIDTH; out_key_o and out_bypass_o SHALL be passed unchanged.
REQ-015 Latency from input transfer to out_valid_o SHALL be exactly 2 cycles when out_ready_i is held high; throughput SHALL be 1 per cycle.
REQ-016 Backpressure SHALL use a 2-entry output skid buffer; in_ready_o SHALL be high iff the buffer plus in-flight entries total fewer than 2.
REQ-017 No lookup SHALL be dropped, duplicated or reordered under any out_ready_i pattern.
REQ-018 When an mm write and a read hit the same address in the same cycle, the read SHALL return the old data.
REQ-019 A write SHALL be visible to a read issued on the next cycle or later.
REQ-020 Writes SHALL be accepted every cycle regardless of the handshake state.
REQ-021 out_* data SHALL be held stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-022 While rst_i=1: out_valid_o=0, in_ready_o=0, all pipeline and skid valids cleared, and in-flight lookups discarded.
REQ-023 in_ready_o SHALL be 1 on the first cycle after rst_i falls.
REQ-024 RAM contents SHALL NOT be reset; data regs need no reset.
REQ-025 A reset mid-stall SHALL leave no residual output.

Configuration
REQ-026 With QSTAGE_NARY_MATCH_EN defined, the block SHALL add port out_match_o out 1, equal to 1 iff in_key == key[postfix] and postfix < FANOUT-1, aligned with out_valid_o and reset to 0.
REQ-027 Without QSTAGE_NARY_MATCH_EN, the port and its compare logic SHALL be absent.

Structure
REQ-028 Package qtree_pkg SHALL hold the node key-array typedef, the lookup payload struct {key, addr} and a clog2-based FANOUT_BITS helper; qstage_nary imports it.
REQ-029 The skid buffer SHALL be the sub-module qstage_skid (params DATA_WIDTH; valid/ready both sides, 2 entries).
REQ-030 Elaboration SHALL fail if FANOUT is not a power of two or is outside 2..16, or if RAM_ADDR_WIDTH > ADDR_WIDTH.

Verification (FANOUT=4, KEY_WIDTH=16, ADDR_WIDTH=8, RAM_ADDR_WIDTH=4)
REQ-031 Write addr 3 = {30,20,10}; lookups key 15/20/31 at addr 3 -> out_addr 0x0D/0x0D/0x0F two cycles later; match (if enabled) 0/1/0.
REQ-032 Back-to-back 16 lookups, out_ready_i=1 -> 16 outputs on consecutive cycles, in order, bypass preserved.
REQ-033 out_ready_i random 30% high over 1000 lookups -> scoreboard exact match, no loss, data stable while stalled, in_ready_o low when 2 entries held.
REQ-034 Same-cycle write addr 3 = {300,200,100} with lookup key 150 at addr 3 -> postfix 3 (old data); the same lookup one cycle later -> postfix 1.
REQ-035 Assert rst_i for 1 cycle with 2 entries stalled -> out_valid_o=0 next cycle, in_ready_o=1 the cycle after, and no stale outputs after out_ready_i rises.
